// File: rtl/parallel_out_display_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : parallel_out_display_pkg
//  Description : Shared types and constants for the decimal 7-segment display
//                path: converter FSM states, digit counts and segment codes.
//  Revision    : 1.0  initial release
// ============================================================================
package parallel_out_display_pkg;

    // Converter FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int BCD_DIGITS  = 10;
    localparam int DISP_DIGITS = 8;

    // Active-low segment patterns {g,f,e,d,c,b,a} for decimal digits 0..9
    localparam logic [6:0] SEG_CODE [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Nibble to segment pattern; non-decimal nibbles show nothing
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] code;
        code = SEG_BLANK;
        if (nib <= 4'd9) begin
            code = SEG_CODE[nib];
        end
        return code;
    endfunction

endpackage : parallel_out_display_pkg
`default_nettype wire

// File: rtl/parallel_out_display_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_seq
//  Description : Sequential double-dabble converter, 32-bit binary to 10 BCD
//                digits, one add-3/shift iteration per clock.
//  Revision    : 1.0  initial release
// ============================================================================
module bin2bcd_seq
    import parallel_out_display_pkg::*;
(
    input  logic        clk,
    input  logic        rst,     // asynchronous, active-low
    input  logic        start,
    input  logic [31:0] bin,
    output logic        busy,
    output logic        done,
    output logic [39:0] bcd
);

    state_t      r_state;
    logic [31:0] r_shift;
    logic [39:0] r_bcd;
    logic [4:0]  r_cnt;
    logic        r_busy;
    logic        r_done;
    logic [39:0] w_adj;

    // Add 3 to every BCD nibble that is 5 or more before the shift
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // Converter FSM and shift datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_shift <= bin;
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_bcd   <= {w_adj[38:0], r_shift[31]};
                    r_shift <= {r_shift[30:0], 1'b0};
                    r_cnt   <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign bcd  = r_bcd;

endmodule : bin2bcd_seq
`default_nettype wire

// File: rtl/parallel_out_display.sv
`default_nettype none
// ============================================================================
//  Module      : parallel_out_display
//  Description : Shows a 32-bit binary value in decimal on an 8-digit
//                multiplexed active-low 7-segment display. Re-converts
//                whenever the input differs from the last converted value.
//  Revision    : 1.0  initial release
// ============================================================================
module parallel_out_display
    import parallel_out_display_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter bit LZB      = 1'b1
) (
    input  logic        clk,
    input  logic        rst,       // asynchronous, active-low
    input  logic [31:0] data_in,
    output logic [6:0]  seg,
    output logic [7:0]  an,
    output logic        busy,
    output logic        overflow
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [31:0]   r_last_val;
    logic [31:0]   r_disp_bcd;
    logic          r_overflow;
    logic [PW-1:0] r_presc;
    logic [2:0]    r_digit_idx;
    logic [6:0]    r_seg;
    logic [7:0]    r_an;

    logic          w_start;
    logic          w_busy;
    logic          w_done;
    logic [39:0]   w_bcd;
    logic [31:0]   w_upper;
    logic          w_blank;

    // A new conversion is launched only while the converter is idle
    assign w_start = !w_busy && (data_in != r_last_val);

    bin2bcd_seq u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (w_start),
        .bin   (data_in),
        .busy  (w_busy),
        .done  (w_done),
        .bcd   (w_bcd)
    );

    // Track the converted value and latch finished results for display
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_val <= '0;
            r_disp_bcd <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_start) begin
                r_last_val <= data_in;
            end
            if (w_done) begin
                r_disp_bcd <= w_bcd[31:0];
                r_overflow <= |w_bcd[39:32];
            end
        end
    end

    // Digit slot timing: prescaler wraps every SCAN_DIV cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc     <= '0;
            r_digit_idx <= '0;
        end else if (r_presc == PW'(SCAN_DIV - 1)) begin
            r_presc     <= '0;
            r_digit_idx <= r_digit_idx + 3'd1;
        end else begin
            r_presc     <= r_presc + PW'(1);
        end
    end

    // Current digit and all above it; all-zero means a leading zero
    assign w_upper = r_disp_bcd >> {r_digit_idx, 2'b00};
    assign w_blank = LZB && (r_digit_idx != 3'd0) && (w_upper == 32'd0);

    // Register segment and anode drive for the current slot
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_seg <= SEG_BLANK;
            r_an  <= 8'hFF;
        end else if (w_blank) begin
            r_seg <= SEG_BLANK;
            r_an  <= 8'hFF;
        end else begin
            r_seg <= seg_decode(w_upper[3:0]);
            r_an  <= ~(8'b1 << r_digit_idx);
        end
    end

    assign seg      = r_seg;
    assign an       = r_an;
    assign busy     = w_busy;
    assign overflow = r_overflow;

endmodule : parallel_out_display
`default_nettype wire

// File: tb/tb_parallel_out_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_parallel_out_display
//  Description : Directed self-checking bench for parallel_out_display with a
//                4-cycle digit slot.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_parallel_out_display;

    logic        clk;
    logic        rst;
    logic [31:0] data_in;
    logic [6:0]  seg;
    logic [7:0]  an;
    logic        busy;
    logic        overflow;

    int n_checks;
    int n_errors;

    logic [7:0] seen;
    logic [6:0] seen_seg [0:7];
    int         bad_an;

    parallel_out_display #(
        .SCAN_DIV (4),
        .LZB      (1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .seg      (seg),
        .an       (an),
        .busy     (busy),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Wait (bounded) for busy to reach a level; expiry shows up as a failed check
    task automatic wait_busy(input string tag, input logic level, input int budget);
        int k;
        k = 0;
        while (busy !== level && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_val(tag, {31'd0, busy}, {31'd0, level});
    endtask

    // Record which digit slots light up and with which segment code
    task automatic observe(input int n);
        logic [7:0] pat;
        logic       hit;
        seen   = '0;
        bad_an = 0;
        for (int k = 0; k < 8; k++) seen_seg[k] = 7'h7F;
        repeat (n) begin
            @(negedge clk);
            if (an == 8'hFF) begin
                if (seg != 7'h7F) bad_an++;
            end else begin
                hit = 1'b0;
                for (int k = 0; k < 8; k++) begin
                    pat = ~(8'd1 << k);
                    if (an == pat) begin
                        seen[k]     = 1'b1;
                        seen_seg[k] = seg;
                        hit         = 1'b1;
                    end
                end
                if (!hit) bad_an++;
            end
        end
    endtask

    initial begin
        int         cnt;
        int         run;
        logic       started;
        logic [7:0] prev;
        logic [7:0] an_log [0:47];

        n_checks = 0;
        n_errors = 0;
        rst      = 1'b0;
        data_in  = 32'd0;
        repeat (3) @(negedge clk);

        // Reset state
        check_val("rst_seg", {25'd0, seg}, 32'h7F);
        check_val("rst_an", {24'd0, an}, 32'hFF);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_ovf", {31'd0, overflow}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Test 1: 340, busy duration and scan content
        data_in = 32'd340;
        wait_busy("t1_busy_rise", 1'b1, 10);
        cnt = 0;
        while (busy && cnt < 60) begin
            @(negedge clk);
            cnt++;
        end
        check_val("t1_busy_len", cnt, 33);
        repeat (2) @(negedge clk);
        observe(64);
        check_val("t1_ovf", {31'd0, overflow}, 32'd0);
        check_val("t1_seen", {24'd0, seen}, 32'h07);
        check_val("t1_d0", {25'd0, seen_seg[0]}, 32'h40);
        check_val("t1_d1", {25'd0, seen_seg[1]}, 32'h19);
        check_val("t1_d2", {25'd0, seen_seg[2]}, 32'h30);
        check_val("t1_bad_an", bad_an, 0);

        // Test 2: single digit 5
        data_in = 32'd5;
        wait_busy("t2_busy_rise", 1'b1, 10);
        wait_busy("t2_busy_fall", 1'b0, 60);
        repeat (2) @(negedge clk);
        observe(64);
        check_val("t2_seen", {24'd0, seen}, 32'h01);
        check_val("t2_d0", {25'd0, seen_seg[0]}, 32'h12);
        check_val("t2_bad_an", bad_an, 0);

        // Test 3: full scale, 4294967295 -> lower digits 94967295
        data_in = 32'hFFFF_FFFF;
        wait_busy("t3_busy_rise", 1'b1, 10);
        wait_busy("t3_busy_fall", 1'b0, 60);
        repeat (2) @(negedge clk);
        observe(64);
        check_val("t3_ovf", {31'd0, overflow}, 32'd1);
        check_val("t3_seen", {24'd0, seen}, 32'hFF);
        check_val("t3_d0", {25'd0, seen_seg[0]}, 32'h12);
        check_val("t3_d1", {25'd0, seen_seg[1]}, 32'h10);
        check_val("t3_d2", {25'd0, seen_seg[2]}, 32'h24);
        check_val("t3_d3", {25'd0, seen_seg[3]}, 32'h78);
        check_val("t3_d4", {25'd0, seen_seg[4]}, 32'h02);
        check_val("t3_d5", {25'd0, seen_seg[5]}, 32'h10);
        check_val("t3_d6", {25'd0, seen_seg[6]}, 32'h19);
        check_val("t3_d7", {25'd0, seen_seg[7]}, 32'h10);

        // Test 4: 100, then 200 during SHIFT; first result shown, then reconverted
        data_in = 32'd100;
        wait_busy("t4_busy_rise", 1'b1, 10);
        repeat (10) @(negedge clk);
        data_in = 32'd200;
        wait_busy("t4_busy_fall", 1'b0, 60);
        @(negedge clk);
        check_val("t4_restart", {31'd0, busy}, 32'd1);
        check_val("t4_ovf", {31'd0, overflow}, 32'd0);
        observe(32);
        check_val("t4_first_seen", {24'd0, seen}, 32'h07);
        check_val("t4_first_d2", {25'd0, seen_seg[2]}, 32'h79);
        check_val("t4_first_d0", {25'd0, seen_seg[0]}, 32'h40);
        wait_busy("t4_busy_fall2", 1'b0, 60);
        repeat (2) @(negedge clk);
        observe(64);
        check_val("t4_final_seen", {24'd0, seen}, 32'h07);
        check_val("t4_final_d2", {25'd0, seen_seg[2]}, 32'h24);
        check_val("t4_final_d1", {25'd0, seen_seg[1]}, 32'h40);

        // Test 5: reset in the middle of a conversion of 77
        data_in = 32'd77;
        wait_busy("t5_busy_rise", 1'b1, 10);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("t5_rst_an", {24'd0, an}, 32'hFF);
        check_val("t5_rst_seg", {25'd0, seg}, 32'h7F);
        check_val("t5_rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        wait_busy("t5_busy_rise2", 1'b1, 10);
        wait_busy("t5_busy_fall", 1'b0, 60);
        repeat (2) @(negedge clk);
        observe(64);
        check_val("t5_seen", {24'd0, seen}, 32'h03);
        check_val("t5_d0", {25'd0, seen_seg[0]}, 32'h78);
        check_val("t5_d1", {25'd0, seen_seg[1]}, 32'h78);

        // Test 6: scan cadence with all 8 digits lit
        data_in = 32'd12345678;
        wait_busy("t6_busy_rise", 1'b1, 10);
        wait_busy("t6_busy_fall", 1'b0, 60);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            an_log[i] = an;
        end
        started = 1'b0;
        run     = 0;
        prev    = an_log[0];
        cnt     = 0;
        for (int i = 1; i < 48; i++) begin
            run++;
            if (an_log[i] != prev) begin
                if (started) begin
                    check_val("t6_slot_len", run, 4);
                end
                check_val("t6_rotate", {24'd0, an_log[i]}, {24'd0, prev[6:0], prev[7]});
                started = 1'b1;
                run     = 0;
                cnt++;
            end
            if (an_log[i] == 8'hFF) cnt = cnt - 100;
            prev = an_log[i];
        end
        check_val("t6_changes", cnt, 11);

        // data_in = 0 shows a single zero on digit 0
        data_in = 32'd0;
        wait_busy("t6_busy_rise0", 1'b1, 10);
        wait_busy("t6_busy_fall0", 1'b0, 60);
        repeat (2) @(negedge clk);
        observe(64);
        check_val("t6_zero_seen", {24'd0, seen}, 32'h01);
        check_val("t6_zero_d0", {25'd0, seen_seg[0]}, 32'h40);
        check_val("t6_zero_bad_an", bad_an, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_parallel_out_display
`default_nettype wire
